// File: rtl/idct_pkg.sv
// Shared constants and types for the 8-point IDCT datapath and its neighbours.
package idct_pkg;

  localparam int unsigned DW = 32;  // coefficient / sample width
  localparam int unsigned IW = 48;  // accumulator width
  localparam int unsigned QS = 12;  // fractional bits of the cosine constants

  typedef logic signed [IW-1:0] acc_t;
  typedef logic signed [DW-1:0] smp_t;

  // round(2048*cos(k*pi/16)); the DC weight is C4
  localparam acc_t C1 = acc_t'(2009);
  localparam acc_t C2 = acc_t'(1892);
  localparam acc_t C3 = acc_t'(1703);
  localparam acc_t C4 = acc_t'(1448);
  localparam acc_t C5 = acc_t'(1138);
  localparam acc_t C6 = acc_t'(784);
  localparam acc_t C7 = acc_t'(400);

endpackage

// File: rtl/idct_round_sat.sv
// Combinational round-half-up, arithmetic right shift by QS, and clamp to DW bits.
module idct_round_sat
  import idct_pkg::*;
(
  input  logic signed [IW-1:0] din,
  output logic signed [DW-1:0] dout
);

  localparam acc_t Half = acc_t'(2 ** (QS - 1));
  localparam acc_t MaxS = {{(IW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam acc_t MinS = {{(IW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  acc_t biased;
  acc_t shifted;

  // Bias, shift, then clamp anything outside the signed DW range.
  always_comb begin
    biased  = din + Half;
    shifted = biased >>> QS;
    if (shifted > MaxS) begin
      dout = {1'b0, {(DW - 1){1'b1}}};
    end else if (shifted < MinS) begin
      dout = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      dout = shifted[DW-1:0];
    end
  end

endmodule

// File: rtl/idct_1d.sv
// 8-point 1-D inverse DCT: products, sums, butterfly, round/saturate (4 stages).
module idct_1d
  import idct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] I0,
  input  logic signed [DW-1:0] I1,
  input  logic signed [DW-1:0] I2,
  input  logic signed [DW-1:0] I3,
  input  logic signed [DW-1:0] I4,
  input  logic signed [DW-1:0] I5,
  input  logic signed [DW-1:0] I6,
  input  logic signed [DW-1:0] I7,
  output logic signed [DW-1:0] A0,
  output logic signed [DW-1:0] A1,
  output logic signed [DW-1:0] A2,
  output logic signed [DW-1:0] A3,
  output logic signed [DW-1:0] A4,
  output logic signed [DW-1:0] A5,
  output logic signed [DW-1:0] A6,
  output logic signed [DW-1:0] A7,
  output logic                 valid
);

  // Odd cosine weights indexed 0..3 for C1, C3, C5, C7.
  localparam acc_t COdd [4] = '{C1, C3, C5, C7};

  acc_t x [8];
  acc_t xo[4];

  acc_t a0_q, a1_q, b0_q, b1_q;
  acc_t odd_q [4][4];  // odd_q[k][j] = COdd[k] * X(2j+1)
  acc_t e_q [4];
  acc_t d_q [4];
  acc_t p_q [8];
  smp_t rs  [8];
  smp_t a_q [8];
  logic [3:0] v_q;

  assign x[0] = acc_t'(I0);
  assign x[1] = acc_t'(I1);
  assign x[2] = acc_t'(I2);
  assign x[3] = acc_t'(I3);
  assign x[4] = acc_t'(I4);
  assign x[5] = acc_t'(I5);
  assign x[6] = acc_t'(I6);
  assign x[7] = acc_t'(I7);

  assign xo[0] = x[1];
  assign xo[1] = x[3];
  assign xo[2] = x[5];
  assign xo[3] = x[7];

  // Stage 1: even-part products and all sixteen odd products.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) begin
          odd_q[k][j] <= '0;
        end
      end
    end else if (en) begin
      a0_q <= C4 * (x[0] + x[4]);
      a1_q <= C4 * (x[0] - x[4]);
      b0_q <= C2 * x[2] + C6 * x[6];
      b1_q <= C6 * x[2] - C2 * x[6];
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) begin
          odd_q[k][j] <= COdd[k] * xo[j];
        end
      end
    end
  end

  // Stage 2: even sums e0..e3 and signed odd sums d0..d3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 4; n++) begin
        e_q[n] <= '0;
        d_q[n] <= '0;
      end
    end else if (en) begin
      e_q[0] <= a0_q + b0_q;
      e_q[1] <= a1_q + b1_q;
      e_q[2] <= a1_q - b1_q;
      e_q[3] <= a0_q - b0_q;
      d_q[0] <= odd_q[0][0] + odd_q[1][1] + odd_q[2][2] + odd_q[3][3];
      d_q[1] <= odd_q[1][0] - odd_q[3][1] - odd_q[0][2] - odd_q[2][3];
      d_q[2] <= odd_q[2][0] - odd_q[0][1] + odd_q[3][2] + odd_q[1][3];
      d_q[3] <= odd_q[3][0] - odd_q[2][1] + odd_q[1][2] - odd_q[0][3];
    end
  end

  // Stage 3: output butterfly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 8; n++) begin
        p_q[n] <= '0;
      end
    end else if (en) begin
      for (int n = 0; n < 4; n++) begin
        p_q[n]     <= e_q[n] + d_q[n];
        p_q[7 - n] <= e_q[n] - d_q[n];
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_rs
    idct_round_sat u_rs (
      .din  (p_q[g]),
      .dout (rs[g])
    );
  end

  // Stage 4: register rounded, saturated samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 8; n++) begin
        a_q[n] <= '0;
      end
    end else if (en) begin
      for (int n = 0; n < 8; n++) begin
        a_q[n] <= rs[n];
      end
    end
  end

  // Valid shift register tracks data through the four stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= {v_q[2:0], in_valid};
    end
  end

  assign valid = v_q[3];
  assign A0 = a_q[0];
  assign A1 = a_q[1];
  assign A2 = a_q[2];
  assign A3 = a_q[3];
  assign A4 = a_q[4];
  assign A5 = a_q[5];
  assign A6 = a_q[6];
  assign A7 = a_q[7];

endmodule

// File: tb/tb_idct_1d.sv
// Self-checking bench for idct_1d: directed vectors plus randomized stream vs. a matrix model.
module tb_idct_1d;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  int   xin[8] = '{default: 0};
  logic signed [31:0] I0, I1, I2, I3, I4, I5, I6, I7;
  logic signed [31:0] A0, A1, A2, A3, A4, A5, A6, A7;
  logic valid;
  int   aobs[8];

  int n_chk = 0;
  int n_pass = 0;

  // Expected-output delay line: slot 3 is what the outputs should show.
  bit mv[4];
  int ma[4][8];

  localparam int Ct[9] = '{2048, 2009, 1892, 1703, 1448, 1138, 784, 400, 0};

  assign I0 = xin[0];
  assign I1 = xin[1];
  assign I2 = xin[2];
  assign I3 = xin[3];
  assign I4 = xin[4];
  assign I5 = xin[5];
  assign I6 = xin[6];
  assign I7 = xin[7];
  assign aobs[0] = A0;
  assign aobs[1] = A1;
  assign aobs[2] = A2;
  assign aobs[3] = A3;
  assign aobs[4] = A4;
  assign aobs[5] = A5;
  assign aobs[6] = A6;
  assign aobs[7] = A7;

  idct_1d dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .I0       (I0),
    .I1       (I1),
    .I2       (I2),
    .I3       (I3),
    .I4       (I4),
    .I5       (I5),
    .I6       (I6),
    .I7       (I7),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .A4       (A4),
    .A5       (A5),
    .A6       (A6),
    .A7       (A7),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Integer IDCT basis weight for coefficient k at sample n: Q12 cos((2n+1)k*pi/16).
  function automatic longint wgt(int k, int n);
    int m;
    if (k == 0) return longint'(Ct[4]);
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -longint'(Ct[16 - m]);
    return longint'(Ct[m]);
  endfunction

  task automatic ref_idct(input int x[8], output int y[8]);
    longint s, r;
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += wgt(k, n) * longint'(x[k]);
      r = (s + 2048) >>> 12;
      if (r > 64'sd2147483647) r = 64'sd2147483647;
      if (r < -64'sd2147483648) r = -64'sd2147483648;
      y[n] = int'(r);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      ma[i] = '{default: 0};
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check at negedge.
  task automatic step();
    int y[8];
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else if (en) begin
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i - 1];
        ma[i] = ma[i - 1];
      end
      ref_idct(xin, y);
      ma[0] = y;
      mv[0] = in_valid;
    end
    @(negedge clk);
    check("valid", longint'(valid), longint'(mv[3]));
    for (int n = 0; n < 8; n++) check($sformatf("A%0d", n), aobs[n], ma[3][n]);
  endtask

  // Send one vector, wait the pipeline latency, compare selected outputs to constants.
  task automatic run_vec(input string tag, input int x[8], input int e[8], input bit [7:0] mask);
    xin = x;
    in_valid = 1'b1;
    step();
    xin = '{default: 0};
    in_valid = 1'b0;
    repeat (3) step();
    check({tag, "_valid"}, longint'(valid), 1);
    for (int n = 0; n < 8; n++) begin
      if (mask[n]) check($sformatf("%s_A%0d", tag, n), aobs[n], e[n]);
    end
  endtask

  initial begin
    int lat;
    int got[$];
    int snap[8];
    logic snap_v;
    longint a7_sat;
    int imax;

    model_clear();

    // Reset held low for three cycles.
    en = 1'b1;
    repeat (3) begin
      step();
      check("rst_valid", longint'(valid), 0);
      check("rst_A0", aobs[0], 0);
    end
    reset = 1'b1;

    // First vector after release: all zero, exact latency.
    xin = '{default: 0};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!valid && lat < 8) begin
      step();
      lat++;
    end
    check("latency", lat, 4);
    check("zero_A3", aobs[3], 0);

    run_vec("dc", '{8, 0, 0, 0, 0, 0, 0, 0}, '{3, 3, 3, 3, 3, 3, 3, 3}, 8'hFF);
    run_vec("ac", '{0, 4096, 0, 0, 0, 0, 0, 0},
            '{2009, 1703, 1138, 400, -400, -1138, -1703, -2009}, 8'hFF);

    imax = 32'h7FFF_FFFF;
    a7_sat = (64'sd322 * 64'sd2147483647 + 64'sd2048) >>> 12;
    run_vec("sat", '{imax, imax, imax, imax, imax, imax, imax, imax},
            '{imax, 0, 0, 0, 0, 0, 0, int'(a7_sat)}, 8'h81);

    // Stall: three vectors back to back, then en low for five cycles.
    in_valid = 1'b1;
    xin = '{8, 0, 0, 0, 0, 0, 0, 0};
    step();
    xin = '{0, 4096, 0, 0, 0, 0, 0, 0};
    step();
    xin = '{default: 0};
    step();
    in_valid = 1'b0;
    en = 1'b0;
    snap = aobs;
    snap_v = valid;
    repeat (5) begin
      in_valid = 1'b1;
      step();
      check("stall_valid", longint'(valid), longint'(snap_v));
      check("stall_A0", aobs[0], snap[0]);
      check("stall_A7", aobs[7], snap[7]);
    end
    in_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid) got.push_back(aobs[0]);
    end
    check("stall_count", got.size(), 3);
    if (got.size() >= 3) begin
      check("stall_ord0", got[0], 3);
      check("stall_ord1", got[1], 2009);
      check("stall_ord2", got[2], 0);
    end

    // Mid-stream reset with three vectors in flight.
    in_valid = 1'b1;
    repeat (3) begin
      for (int n = 0; n < 8; n++) xin[n] = int'($urandom_range(0, 2000)) - 1000;
      step();
    end
    in_valid = 1'b0;
    xin = '{default: 0};
    #2 reset = 1'b0;
    #1;
    check("rst_async_valid", longint'(valid), 0);
    check("rst_async_A0", aobs[0], 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("no_stale", longint'(valid), 0);
    end

    // Randomized stream with random stalls.
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      for (int n = 0; n < 8; n++) begin
        if ($urandom_range(0, 3) == 0) xin[n] = int'($urandom);
        else xin[n] = int'($urandom_range(0, 2000)) - 1000;
      end
      step();
    end
    en = 1'b1;
    in_valid = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idct_1d.md
Name: idct_1d

Overview:
- 8-point 1-D inverse DCT; the decode-side counterpart of the forward DCT_1D pipeline.
- Consumes one row or column of eight signed 32-bit coefficients per cycle.
- Produces eight signed 32-bit spatial samples after a fixed 4-stage pipeline.
- Two instances plus a transpose buffer form the 2-D IDCT in the JPEG decode path.

Parameters:
- DW, 32, input coefficient and output sample width (signed two's complement).
- IW, 48, internal accumulator width.
- QS, 12, fractional bits of cosine constants; right-shift applied at output.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all pipeline state.
- en  input  1  global advance; when 0, every pipeline register holds.
- in_valid  input  1  I0..I7 carry a valid coefficient vector this cycle.
- I0..I7  input  DW each  DCT coefficients X[0]..X[7], signed.
- A0..A7  output  DW each  spatial samples y[0]..y[7], signed, registered.
- valid  output  1  A0..A7 hold a valid result.

Behaviour:
- Cosine constants, Q12 (round(2048*cos(kπ/16))): C1=2009, C2=1892, C3=1703, C4=1448, C5=1138, C6=784, C7=400. The DC weight equals C4.
- Stage 1 (products), registered when en=1:
  - a0 = C4*(X0+X4), a1 = C4*(X0−X4)
  - b0 = C2*X2 + C6*X6, b1 = C6*X2 − C2*X6
  - All sixteen odd products Ck*Xj for k in {1,3,5,7} and j in {1,3,5,7}.
  - All arithmetic is sign-extended to IW.
- Stage 2 (sums):
  - e0 = a0+b0, e1 = a1+b1, e2 = a1−b1, e3 = a0−b0
  - d0 = C1X1+C3X3+C5X5+C7X7
  - d1 = C3X1−C7X3−C1X5−C5X7
  - d2 = C5X1−C1X3+C7X5+C3X7
  - d3 = C7X1−C5X3+C3X5−C1X7
- Stage 3 (butterfly): for n=0..3, p[n] = e_n + d_n and p[7−n] = e_n − d_n.
- Stage 4 (round and saturate):
  - A[n] = sat32((p[n] + 2^(QS−1)) >>> QS), arithmetic shift, i.e. round-half-up.
  - Results above 2^31−1 clamp to 0x7FFFFFFF; results below −2^31 clamp to 0x80000000.
- Valid pipeline:
  - v1..v4 shift register; v1 <= in_valid, and valid = v4.
  - Data registers load on en=1 regardless of valid; downstream logic ignores data when valid=0.
- Latency: exactly 4 en-high cycles from in_valid sample to valid output.
- Throughput: one vector per cycle; back-to-back in_valid is supported with no bubbles.
- en=0: all data and valid registers hold; outputs are frozen, and a held valid stays high.
- in_valid sampled while en=0 is ignored; the upstream producer must hold its inputs.
- Reset:
  - Asserting reset (low) asynchronously clears all data registers, v1..v4 and valid to 0, and A0..A7 to 0.
  - Reset mid-stream discards all in-flight vectors.
  - Release is synchronous to clk; the first vector is accepted on the first en-high edge after release.
- No overflow is possible inside IW=48: |X| < 2^31 and the sum of |C| < 2^14, giving < 2^45.

Decomposition:
- Shared package idct_pkg:
  - DW, IW, QS
  - Constants C1..C7
  - Typedefs for the IW-wide accumulator and the DW-wide sample
  - A forward-DCT team module may reuse the same constants.
- One sub-module, idct_round_sat: IW-bit input to DW-bit output, combinational round, shift and saturate.
  - Instantiated eight times in stage 4.
  - Also reusable by the quantiser/dequantiser blocks.

Test Plan:
- Reset and all-zero:
  - Stimulus: hold reset=0 for 3 cycles; check; release; apply I*=0 with in_valid=1, en=1.
  - Required: valid=0 and A*=0 during reset; valid rises exactly 4 cycles after release-edge input, with all A=0.
- DC only:
  - Stimulus: X0=8, others 0.
  - Required: all A0..A7 = 3 after 4 cycles, since (11584+2048)>>>12 = 3.
- Single AC:
  - Stimulus: X1=4096, others 0.
  - Required: A0..A7 = 2009, 1703, 1138, 400, −400, −1138, −1703, −2009.
- Saturation:
  - Stimulus: all X = 0x7FFFFFFF.
  - Required: A0 = 0x7FFFFFFF (clamped); A7 = (322*(2^31−1)+2048)>>>12, not clamped.
- Stall:
  - Stimulus: stream three vectors back-to-back (the DC, AC and zero vectors above), then drop en for 5 cycles mid-flight.
  - Required: outputs and valid frozen during the stall; after en returns, results arrive in order with no loss or duplication.
- Mid-stream reset:
  - Stimulus: assert reset for 1 cycle while 3 vectors are in flight.
  - Required: valid=0 immediately, asynchronously; no stale result ever appears afterwards.
